// File: rtl/uart_trx.sv
// uart_trx: 8N1 UART transmitter and receiver; define UART_RX_FRAME_CHECK_EN to drop frames with a bad stop bit
module uart_trx #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       i_clock,
    input  logic       i_rst_n,
    input  logic       i_tx_dv,
    input  logic [7:0] i_tx_byte,
    output logic       o_tx_active,
    output logic       o_tx_serial,
    output logic       o_tx_done,
    input  logic       i_rx_serial,
    output logic       o_rx_dv,
    output logic [7:0] o_rx_byte
);
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, CLEANUP} state_e;

    state_e          tx_state_q, tx_state_d;
    logic [CW-1:0]   tx_cnt_q, tx_cnt_d;
    logic [2:0]      tx_bit_q, tx_bit_d;
    logic [7:0]      tx_byte_q, tx_byte_d;
    logic            tx_serial_q, tx_serial_d;
    logic            tx_active_q, tx_active_d;
    logic            tx_done_q, tx_done_d;
    logic            tx_last;

    state_e          rx_state_q, rx_state_d;
    logic [1:0]      rx_sync_q;
    logic [CW-1:0]   rx_cnt_q, rx_cnt_d;
    logic [2:0]      rx_bit_q, rx_bit_d;
    logic [7:0]      rx_shift_q, rx_shift_d;
    logic [7:0]      rx_byte_q, rx_byte_d;
    logic            rx_dv_q, rx_dv_d;
    logic            rx_s, rx_last;

    assign o_tx_active = tx_active_q;
    assign o_tx_serial = tx_serial_q;
    assign o_tx_done   = tx_done_q;
    assign o_rx_dv     = rx_dv_q;
    assign o_rx_byte   = rx_byte_q;
    assign tx_last     = tx_cnt_q == LAST;
    assign rx_last     = rx_cnt_q == LAST;
    assign rx_s        = rx_sync_q[1];

    // TX state and registered line outputs
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_state_q  <= IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_byte_q   <= '0;
            tx_serial_q <= 1'b1;
            tx_active_q <= 1'b0;
            tx_done_q   <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_byte_q   <= tx_byte_d;
            tx_serial_q <= tx_serial_d;
            tx_active_q <= tx_active_d;
            tx_done_q   <= tx_done_d;
        end
    end

    // TX next state: next line level is computed so the bit appears right on its boundary edge
    always_comb begin
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_last ? '0 : tx_cnt_q + CW'(1);
        tx_bit_d    = tx_bit_q;
        tx_byte_d   = tx_byte_q;
        tx_serial_d = tx_serial_q;
        tx_active_d = tx_active_q;
        tx_done_d   = 1'b0;
        case (tx_state_q)
            IDLE: begin
                tx_cnt_d    = '0;
                tx_bit_d    = '0;
                tx_serial_d = 1'b1;
                tx_active_d = 1'b0;
                if (i_tx_dv) begin
                    tx_byte_d   = i_tx_byte;
                    tx_serial_d = 1'b0;
                    tx_active_d = 1'b1;
                    tx_state_d  = START;
                end
            end
            START: if (tx_last) begin
                tx_serial_d = tx_byte_q[0];
                tx_state_d  = DATA;
            end
            DATA: if (tx_last) begin
                if (tx_bit_q == 3'd7) begin
                    tx_serial_d = 1'b1;
                    tx_state_d  = STOP;
                end else begin
                    tx_bit_d    = tx_bit_q + 3'd1;
                    tx_serial_d = tx_byte_q[tx_bit_d];
                end
            end
            STOP: if (tx_last) begin
                tx_done_d   = 1'b1;
                tx_active_d = 1'b0;
                tx_state_d  = CLEANUP;
            end
            default: begin
                tx_cnt_d   = '0;
                tx_state_d = IDLE;
            end
        endcase
    end

    // RX synchronizer, state and output registers
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_sync_q  <= 2'b11;
            rx_state_q <= IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_byte_q  <= '0;
            rx_dv_q    <= 1'b0;
        end else begin
            rx_sync_q  <= {rx_sync_q[0], i_rx_serial};
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_byte_q  <= rx_byte_d;
            rx_dv_q    <= rx_dv_d;
        end
    end

    // RX next state: re-check start at half bit, then sample once per bit period
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_last ? '0 : rx_cnt_q + CW'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_byte_d  = rx_byte_q;
        rx_dv_d    = 1'b0;
        case (rx_state_q)
            IDLE: begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_s ? IDLE : START;
            end
            START: if (rx_cnt_q == HALF) begin
                rx_cnt_d   = '0;
                rx_state_d = rx_s ? IDLE : DATA;
            end
            DATA: if (rx_last) begin
                rx_shift_d[rx_bit_q] = rx_s;
                rx_bit_d   = rx_bit_q + 3'd1;
                rx_state_d = rx_bit_q == 3'd7 ? STOP : DATA;
            end
            STOP: if (rx_last) begin
                rx_state_d = CLEANUP;
`ifdef UART_RX_FRAME_CHECK_EN
                rx_dv_d    = rx_s;
                rx_byte_d  = rx_s ? rx_shift_q : rx_byte_q;
`else
                rx_dv_d    = 1'b1;
                rx_byte_d  = rx_shift_q;
`endif
            end
            default: begin
                rx_cnt_d   = '0;
                rx_state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_trx.sv
// tb_uart_trx: randomized loopback bench for uart_trx with a frame-level reference model
module tb_uart_trx;
    localparam int CPB = 87;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       tx_active, tx_serial, tx_done;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       loop, rx_drive, rx_line;

    int n_checks = 0;
    int n_errors = 0;
    int rx_cnt = 0;
    int done_cnt = 0;
    int exp_rx = 0;
    int exp_done = 0;
    logic [7:0] exp_q[$];

    assign rx_line = loop ? tx_serial : rx_drive;

    uart_trx #(.CLKS_PER_BIT(CPB)) dut (
        .i_clock(clk), .i_rst_n(rst_n), .i_tx_dv(tx_dv), .i_tx_byte(tx_byte),
        .o_tx_active(tx_active), .o_tx_serial(tx_serial), .o_tx_done(tx_done),
        .i_rx_serial(rx_line), .o_rx_dv(rx_dv), .o_rx_byte(rx_byte)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every received byte must match the oldest frame still expected
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_done) done_cnt++;
            if (rx_dv) begin
                rx_cnt++;
                if (exp_q.size() != 0) check("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
            end
        end
    end

    // Send one byte over loopback, checking the line at every mid-bit; optionally poke tx_dv mid-frame
    task automatic send(input logic [7:0] b, input int busy_bit);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        exp_q.push_back(b);
        exp_rx++;
        exp_done++;
        @(negedge clk);
        tx_dv = 1'b1;
        tx_byte = b;
        @(negedge clk);
        tx_dv = 1'b0;
        tx_byte = 8'($urandom);
        check("tx_active", 32'(tx_active), 32'd1);
        repeat (CPB / 2) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("tx_bit%0d", k), 32'(tx_serial), 32'(fr[k]));
            if (k < 9) begin
                if (k == busy_bit) begin
                    tx_dv = 1'b1;
                    tx_byte = 8'h55;
                    @(negedge clk);
                    tx_dv = 1'b0;
                    repeat (CPB - 1) @(negedge clk);
                end else begin
                    repeat (CPB) @(negedge clk);
                end
            end
        end
        for (int i = 0; i < 2 * CPB && !tx_done; i++) @(negedge clk);
        check("tx_done", 32'(tx_done), 32'd1);
        check("tx_active_end", 32'(tx_active), 32'd0);
        #1;
        check("rx_count", rx_cnt, exp_rx);
        check("done_count", done_cnt, exp_done);
        check("rx_pending", exp_q.size(), 0);
    endtask

    // Drive a hand-built frame straight onto the RX line
    task automatic drive_rx(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        @(negedge clk);
        loop = 1'b0;
        for (int k = 0; k < 10; k++) begin
            rx_drive = fr[k];
            repeat (CPB) @(negedge clk);
        end
        rx_drive = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        loop = 1'b1;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        tx_dv = 1'b0;
        tx_byte = 8'h00;
        loop = 1'b1;
        rx_drive = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx_serial", 32'(tx_serial), 32'd1);
        check("rst_tx_active", 32'(tx_active), 32'd0);
        check("rst_tx_done", 32'(tx_done), 32'd0);
        check("rst_rx_dv", 32'(rx_dv), 32'd0);
        check("rst_rx_byte", 32'(rx_byte), 32'h00);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        send(8'hAB, -1);
        send(8'h00, -1);
        send(8'hFF, -1);

        @(negedge clk);
        loop = 1'b0;
        rx_drive = 1'b0;
        repeat (20) @(negedge clk);
        rx_drive = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        loop = 1'b1;
        check("glitch_rx_count", rx_cnt, exp_rx);
        check("glitch_rx_byte", 32'(rx_byte), 32'hFF);

        send(8'h3C, 4);
        repeat (11 * CPB) @(negedge clk);
        check("busy_rx_count", rx_cnt, exp_rx);
        check("busy_done_count", done_cnt, exp_done);
        check("busy_tx_idle", 32'(tx_active), 32'd0);

        @(negedge clk);
        tx_dv = 1'b1;
        tx_byte = 8'hC3;
        @(negedge clk);
        tx_dv = 1'b0;
        repeat (4 * CPB + CPB / 2) @(negedge clk);
        check("rst_pre_bit3", 32'(tx_serial), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_tx_serial", 32'(tx_serial), 32'd1);
        check("rst_mid_tx_active", 32'(tx_active), 32'd0);
        check("rst_mid_rx_byte", 32'(rx_byte), 32'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (11 * CPB) @(negedge clk);
        check("rst_mid_rx_count", rx_cnt, exp_rx);
        check("rst_mid_done_count", done_cnt, exp_done);
        send(8'hA5, -1);

        drive_rx(8'h12, 1'b0);
`ifdef UART_RX_FRAME_CHECK_EN
        check("fc_rx_count", rx_cnt, exp_rx);
        check("fc_rx_byte_held", 32'(rx_byte), 32'hA5);
`else
        exp_rx++;
        check("bad_stop_rx_count", rx_cnt, exp_rx);
        check("bad_stop_rx_byte", 32'(rx_byte), 32'h12);
`endif

        for (int i = 0; i < 12; i++) send(8'($urandom), -1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/uart_trx.md
UART_TRX -- requirements
Module: uart_trx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, clocks per serial bit (legal ≥ 4); the default equals 115200 baud at 10 MHz.
REQ-002 SHALL have port i_clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port i_tx_dv  input  1  transmit request strobe, sampled on rising edge.
REQ-005 SHALL have port i_tx_byte  input  8  byte to transmit, captured with i_tx_dv.
REQ-006 SHALL have port o_tx_active  output  1  high while a frame is being transmitted.
REQ-007 SHALL have port o_tx_serial  output  1  serial line out, idle high.
REQ-008 SHALL have port o_tx_done  output  1  one-cycle pulse at end of frame.
REQ-009 SHALL have port i_rx_serial  input  1  asynchronous serial line in, idle high.
REQ-010 SHALL have port o_rx_dv  output  1  one-cycle pulse when a received byte is valid.
REQ-011 SHALL have port o_rx_byte  output  8  last received byte, held until the next valid byte.

Function
REQ-012 Frame format SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1; each bit lasts exactly CLKS_PER_BIT clocks.
REQ-013 TX FSM SHALL have states IDLE, START, DATA, STOP, CLEANUP, with all outputs registered.
REQ-014 TX IDLE: o_tx_serial=1, o_tx_active=0; on i_tx_dv=1, latch i_tx_byte, set o_tx_active=1 and o_tx_serial=0 on that same edge, then go to START.
REQ-015 TX SHALL hold the start bit CLKS_PER_BIT clocks, drive data bits 0..7 CLKS_PER_BIT clocks each, then drive the stop bit CLKS_PER_BIT clocks.
REQ-016 At the end of the stop bit, TX SHALL pulse o_tx_done=1 for one cycle, clear o_tx_active, enter CLEANUP for one cycle, then return to IDLE.
REQ-017 TX SHALL ignore i_tx_dv outside IDLE; the latched byte SHALL NOT change mid-frame.
REQ-018 RX SHALL pass i_rx_serial through a 2-flop synchronizer; all RX decisions SHALL use the synchronized value.
REQ-019 RX FSM SHALL have states IDLE, START, DATA, STOP, CLEANUP.
REQ-020 RX IDLE: on synchronized 0, go to START.
REQ-021 In START, RX SHALL count (CLKS_PER_BIT-1)/2 clocks (43 at default), then re-check the line: 0 goes to DATA; 1 is a glitch and returns to IDLE with no output.
REQ-022 In DATA, RX SHALL sample every CLKS_PER_BIT clocks (mid-bit) into bit positions 0..7 LSB first, then go to STOP.
REQ-023 In STOP, RX SHALL wait CLKS_PER_BIT clocks, sample the stop bit, update o_rx_byte, and pulse o_rx_dv for exactly one cycle on the same edge.
REQ-024 RX SHALL then spend one CLEANUP cycle and return to IDLE; o_rx_dv SHALL be 0 at all other times.
REQ-025 Bit counters SHALL be 3 bits; clock counters SHALL be wide enough for CLKS_PER_BIT-1 and SHALL reset to 0 at each bit boundary.
REQ-026 TX and RX SHALL be fully independent; with o_tx_serial looped to i_rx_serial, every transmitted byte SHALL be received unchanged.

Reset
REQ-027 Asserting i_rst_n=0 SHALL immediately force both FSMs to IDLE and clear all counters.
REQ-028 Reset values SHALL be: o_tx_serial=1, o_tx_active=0, o_tx_done=0, o_rx_dv=0, o_rx_byte=8'h00, synchronizer flops=1.
REQ-029 Reset mid-frame SHALL abort the frame with no o_tx_done or o_rx_dv pulse; release SHALL be taken on the next rising edge.

Configuration
REQ-030 Macro UART_RX_FRAME_CHECK_EN: when defined, a stop-bit sample of 0 SHALL discard the byte (no o_rx_dv, o_rx_byte unchanged) and RX SHALL return to IDLE via CLEANUP.
REQ-031 Without UART_RX_FRAME_CHECK_EN, RX SHALL ignore the stop-bit value and always pulse o_rx_dv with the received byte.

Verification
REQ-032 Loopback, CLKS_PER_BIT=87: i_tx_dv with 8'hAB -> o_rx_dv within 20*87 clocks, o_rx_byte=8'hAB, and one o_tx_done pulse.
REQ-033 Back-to-back: send 8'h00 then 8'hFF, each issued the cycle after o_tx_done -> two o_rx_dv pulses with bytes 00 then FF.
REQ-034 Glitch: i_rx_serial low for 20 clocks then high -> no o_rx_dv, RX back in IDLE.
REQ-035 Busy: i_tx_dv with 8'h55 asserted mid-frame of 8'h3C -> only 3C is transmitted and received.
REQ-036 Reset mid-frame: i_rst_n low during data bit 3 -> o_tx_serial=1 immediately, no o_rx_dv pulse; a later send of 8'hA5 is received correctly.
REQ-037 With UART_RX_FRAME_CHECK_EN: frame 8'h12 driven with stop bit 0 -> no o_rx_dv, o_rx_byte unchanged.
